muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 30 +++
 rtl/muldiv_unit_div_core.sv | 26 ++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared defines: instruction function codes, muldiv op and FSM encodings
package muldiv_unit_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// rtl/muldiv_unit_div_core.sv - one restoring shift-subtract divide step on unsigned magnitudes
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] trial;

    // rem < divisor always holds, so a borrow shows up in the top bit
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};

    always_comb begin
        rem_next = trial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b1};
        if (trial[WIDTH]) begin
            rem_next = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO result registers
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic           accept, last;

    logic           is_div, neg_q, neg_r, b_zero;
    logic [WIDTH:0]   wh;
    logic [WIDTH-1:0] wl, opb;

    logic           a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]   madd;
    logic [WIDTH:0]   mul_wh_n;
    logic [WIDTH-1:0] mul_wl_n;
    logic [WIDTH-1:0] div_rem_n, div_quo_n;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign accept = (state != ST_RUN) && start && !cancel;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    assign a_neg = op_is_signed(op) && a[WIDTH-1];
    assign b_neg = op_is_signed(op) && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Shift-add: {wh, wl} holds the partial product with the multiplier in wl
    assign madd     = wh + (wl[0] ? {1'b0, opb} : '0);
    assign mul_wh_n = {1'b0, madd[WIDTH:1]};
    assign mul_wl_n = {madd[0], wl[WIDTH-1:1]};

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .rem      (wh[WIDTH-1:0]),
        .quo      (wl),
        .divisor  (opb),
        .rem_next (div_rem_n),
        .quo_next (div_quo_n)
    );

    assign prod   = {mul_wh_n[WIDTH-1:0], mul_wl_n};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -div_quo_n : div_quo_n;
    assign rem_s  = neg_r ? -div_rem_n : div_rem_n;

    always_comb begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        if (is_div) begin
            res_hi = rem_s;
            res_lo = b_zero ? '1 : quo_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_RUN;
            ST_RUN: begin
                if (cancel)    state_nx = ST_IDLE;
                else if (last) state_nx = ST_DONE;
            end
            ST_DONE: state_nx = accept ? ST_RUN : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            wh       <= '0;
            wl       <= '0;
            opb      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            is_div <= op_is_div(op);
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (b == '0);
            wh     <= '0;
            wl     <= a_mag;
            opb    <= b_mag;
        end else if (state == ST_RUN && !cancel) begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
                wh <= {1'b0, div_rem_n};
                wl <= div_quo_n;
            end else begin
                wh <= mul_wh_n;
                wl <= mul_wl_n;
            end
            // Sign correction lands together with the final iteration
            if (last) begin
                hi       <= res_hi;
                lo       <= res_lo;
                div_zero <= is_div && b_zero;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed table-driven bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        vec_t v;
        v.name = n; v.op = o; v.a = x; v.b = y; v.hi = eh; v.lo = el; v.dz = edz;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles since the accept edge until done; n0 cycles already elapsed
    task automatic collect(input string n, input int n0, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic edz);
        int cyc;
        bit busy_ok;
        bit got;
        cyc = n0; busy_ok = 1'b1; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s timeout: no done after %0d cycles", n, cyc);
        end else begin
            check({n, " latency"}, 64'(cyc), 64'(W + 1));
            check({n, " busy_window"}, 64'(busy_ok), 64'd1);
            check({n, " busy_at_done"}, 64'(busy), 64'd0);
            check({n, " hi"}, 64'(hi), 64'(eh));
            check({n, " lo"}, 64'(lo), 64'(el));
            check({n, " div_zero"}, 64'(div_zero), 64'(edz));
            @(negedge clk);
            check({n, " single_done"}, 64'(done), 64'd0);
        end
    endtask

    task automatic watch_no_done(input string n, input int ncyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check({n, " quiet"}, 64'(seen), 64'd0);
    endtask

    initial begin
        int cyc;
        bit got;

        add("mult_m3x7",      OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        add("multu_max_sq",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        add("mult_shift",     OP_MULT,  32'h12345678, 32'h100,      32'h00000012, 32'h34567800, 1'b0);
        add("multu_carry",    OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0);
        add("mult_minneg_sq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        add("div_m7_2",       OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        add("divu_7_2",       OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0);
        add("div_minneg_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        add("div_7_m2",       OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
        add("divu_5_0",       OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
        add("mult_clears_dz", OP_MULT,  32'd3,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0);
        add("div_m5_0",       OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        add("divu_100_7",     OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        add("divu_max_1",     OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        resetn = 1'b1;

        foreach (vq[i]) begin
            start_op(vq[i].op, vq[i].a, vq[i].b);
            collect(vq[i].name, 0, vq[i].hi, vq[i].lo, vq[i].dz);
        end

        // Cancel at cycle 10 of DIVU 100/7; previous result is divu_max_1
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel done", 64'(done), 64'd0);
        check("cancel hi_kept", 64'(hi), 64'h0);
        check("cancel lo_kept", 64'(lo), 64'hFFFFFFFF);
        watch_no_done("cancel", 40);
        check("cancel lo_after", 64'(lo), 64'hFFFFFFFF);

        // start pulse during RUN must not disturb the operation
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        @(negedge clk);
        op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        collect("start_in_run", 5, 32'd2, 32'd14, 1'b0);

        // start with cancel in IDLE is ignored
        @(negedge clk);
        op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; cancel = 1'b0; end
        @(negedge clk);
        check("start_cancel busy", 64'(busy), 64'd0);
        check("start_cancel lo", 64'(lo), 64'd14);

        // Back-to-back accept in the DONE cycle
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        check("b2b first_latency", 64'(cyc), 64'(W + 1));
        check("b2b first_hi", 64'(hi), 64'hFFFFFFFE);
        check("b2b first_lo", 64'(lo), 64'h00000001);
        op = OP_DIVU; a = 32'd7; b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b busy_next", 64'(busy), 64'd1);
        check("b2b no_second_done", 64'(done), 64'd0);
        collect("b2b second", 1, 32'd1, 32'd3, 1'b0);

        // Reset at cycle 5 of a DIV
        start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (4) @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_run busy", 64'(busy), 64'd0);
        check("rst_run done", 64'(done), 64'd0);
        check("rst_run hi", 64'(hi), 64'd0);
        check("rst_run lo", 64'(lo), 64'd0);
        watch_no_done("rst_run", 40);
        start_op(OP_DIVU, 32'd7, 32'd2);
        collect("after_reset", 0, 32'd1, 32'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
